// File: rtl/bus_req_scheduler_pkg.sv
// Shared types and constants for the bus request scheduler and its arbiter.
// Latency: n/a. Backpressure: n/a.
package bus_req_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } sched_state_t;

    localparam int TIMEOUT_W = 8;

    // Replicated to DATA_W wherever an error or write response carries data.
    localparam logic ERR_RDATA_BIT = 1'b0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_req_scheduler_rr_arbiter_pick.sv
// Round-robin pick: first set request scanning last+1, last+2, ... modulo N.
// Latency: combinational. Backpressure: none, the caller decides when a pick is consumed.
module rr_arbiter_pick
    import bus_req_scheduler_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % N);
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // i runs to N so the last winner itself is considered last.
        for (int i = 1; i <= N; i++) begin
            if (!any && req[wrap(int'(last) + i)]) begin
                any = 1'b1;
                idx = wrap(int'(last) + i);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_req_scheduler.sv
// Shares one slave bus among NREQ requesters, one access at a time, round-robin.
// Latency: accept cycle 0, strobe cycle 1 (+1 per busy cycle), response next cycle.
// Backpressure: req_ready only in IDLE; slave stalls via bus_busy up to TIMEOUT cycles.
module bus_req_scheduler
    import bus_req_scheduler_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_wen,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wdata,
    output logic                   bus_ren,
    output logic                   bus_wen,
    input  logic [DATA_W-1:0]      bus_rdata,
    input  logic                   bus_busy,
    input  logic                   bus_addr_valid
);

    localparam int IDX_W = idx_width(NREQ);
    localparam logic [TIMEOUT_W-1:0] TO_LIM   = TIMEOUT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0]    ERR_DATA = {DATA_W{ERR_RDATA_BIT}};

    sched_state_t state, state_nxt;

    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     win_idx;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 lat_wen;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [DATA_W-1:0]    res_rdata;
    logic                 res_err;

    logic [NREQ-1:0]  pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic              finish;
    logic              fin_err;
    logic [DATA_W-1:0] fin_rdata;

    rr_arbiter_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign cnt_inc   = cnt + 1'b1;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        finish     = 1'b0;
        fin_err    = 1'b0;
        fin_rdata  = ERR_DATA;
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        bus_ren    = 1'b0;
        bus_wen    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = pick_grant;
                if (pick_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                bus_ren = ~lat_wen;
                bus_wen = lat_wen;
                if (!bus_addr_valid) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (bus_busy) begin
                    // Abort on the TIMEOUT-th consecutive busy cycle.
                    if (cnt_inc == TO_LIM) begin
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end
                end else begin
                    finish    = 1'b1;
                    fin_rdata = lat_wen ? ERR_DATA : bus_rdata;
                end
                if (finish) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid[win_idx] = 1'b1;
                resp_rdata          = res_rdata;
                resp_err            = res_err;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last      <= IDX_W'(NREQ - 1);
            win_idx   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wen   <= 1'b0;
            cnt       <= '0;
            res_rdata <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        win_idx   <= pick_idx;
                        last      <= pick_idx;
                        lat_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        lat_wen   <= req_wen[pick_idx];
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        res_rdata <= fin_rdata;
                        res_err   <= fin_err;
                    end else if (bus_busy) begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_req_scheduler.sv
// Directed bench for bus_req_scheduler (NREQ=3, TIMEOUT=4) with immediate-assertion checks.
module tb_bus_req_scheduler;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_wen;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_ren;
    logic              bus_wen;
    logic [DW-1:0]     bus_rdata;
    logic              bus_busy;
    logic              bus_addr_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_req_scheduler #(
        .NREQ    (NREQ),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (4)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .req_valid      (req_valid),
        .req_wen        (req_wen),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ren        (bus_ren),
        .bus_wen        (bus_wen),
        .bus_rdata      (bus_rdata),
        .bus_busy       (bus_busy),
        .bus_addr_valid (bus_addr_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Move to the drive point of the next cycle (2 time units after the rising edge).
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle before checking.
    task automatic settle();
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] exp_g;
        rst            = 1'b1;
        req_valid      = '0;
        req_wen        = '0;
        req_addr       = '0;
        req_wdata      = '0;
        bus_rdata      = '0;
        bus_busy       = 1'b0;
        bus_addr_valid = 1'b1;

        // ---- reset state
        next_cyc();
        next_cyc();
        settle();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'h0);
        chk("rst_resp_err", 64'(resp_err), 64'h0);
        chk("rst_strobes", 64'({bus_ren, bus_wen}), 64'h0);
        chk("rst_bus_addr", 64'(bus_addr), 64'h0);
        rst = 1'b0;

        // ---- single read, requester 1
        next_cyc();
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 32'h8000_0004;
        bus_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rd1_req_ready_c0", 64'(req_ready), 64'h2);
        next_cyc();
        req_valid = '0;
        settle();
        chk("rd1_ren_c1", 64'({bus_ren, bus_wen}), 64'h2);
        chk("rd1_addr_c1", 64'(bus_addr), 64'h8000_0004);
        chk("rd1_resp_valid_c1", 64'(resp_valid), 64'h0);
        next_cyc();
        bus_rdata = 32'h0BAD_0BAD;
        settle();
        chk("rd1_resp_valid_c2", 64'(resp_valid), 64'h2);
        chk("rd1_rdata_c2", 64'(resp_rdata), 64'hDEAD_BEEF);
        chk("rd1_err_c2", 64'(resp_err), 64'h0);
        chk("rd1_strobes_c2", 64'({bus_ren, bus_wen}), 64'h0);
        next_cyc();
        settle();
        chk("rd1_resp_valid_c3", 64'(resp_valid), 64'h0);
        chk("rd1_rdata_c3", 64'(resp_rdata), 64'h0);

        // ---- round robin from reset, all three requesting
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'h100 * (i + 1);
        req_valid = 3'b111;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) next_cyc();
            bus_rdata = 32'hA5A5_0000 | k;
            settle();
            exp_g = (k % 3 == 0) ? 3'(1 << ((k / 3) % 3)) : 3'b000;
            chk($sformatf("rr_req_ready_c%0d", k), 64'(req_ready), 64'(exp_g));
            if (k % 3 == 1) begin
                chk($sformatf("rr_bus_addr_c%0d", k), 64'(bus_addr),
                    64'(32'h100 * (((k / 3) % 3) + 1)));
            end
            if (k % 3 == 2) begin
                chk($sformatf("rr_resp_valid_c%0d", k), 64'(resp_valid),
                    64'(1 << ((k / 3) % 3)));
                chk($sformatf("rr_rdata_c%0d", k), 64'(resp_rdata),
                    64'(32'hA5A5_0000 | (k - 1)));
            end
        end
        req_valid = '0;
        next_cyc();

        // ---- write with 2 wait-states, requester 2 (last is 2, so 2 is scanned last)
        req_valid = 3'b100;
        req_wen   = 3'b100;
        req_addr[2*AW +: AW]  = 32'h0000_0010;
        req_wdata[2*DW +: DW] = 32'h1234_5678;
        bus_rdata = 32'hFFFF_FFFF;
        settle();
        chk("wr_req_ready_c0", 64'(req_ready), 64'h4);
        next_cyc();
        req_valid = '0;
        req_wen   = '0;
        bus_busy  = 1'b1;
        settle();
        chk("wr_strobes_c1", 64'({bus_ren, bus_wen}), 64'h1);
        chk("wr_wdata_c1", 64'(bus_wdata), 64'h1234_5678);
        next_cyc();
        settle();
        chk("wr_strobes_c2", 64'({bus_ren, bus_wen}), 64'h1);
        next_cyc();
        bus_busy = 1'b0;
        settle();
        chk("wr_strobes_c3", 64'({bus_ren, bus_wen}), 64'h1);
        chk("wr_resp_valid_c3", 64'(resp_valid), 64'h0);
        next_cyc();
        settle();
        chk("wr_resp_valid_c4", 64'(resp_valid), 64'h4);
        chk("wr_err_c4", 64'(resp_err), 64'h0);
        chk("wr_rdata_c4", 64'(resp_rdata), 64'h0);
        chk("wr_strobes_c4", 64'({bus_ren, bus_wen}), 64'h0);

        // ---- unmapped address, requester 0
        next_cyc();
        req_valid = 3'b001;
        req_addr[0*AW +: AW] = 32'hF000_0000;
        bus_addr_valid = 1'b0;
        bus_rdata = 32'hDEAD_BEEF;
        settle();
        chk("um_req_ready_c0", 64'(req_ready), 64'h1);
        next_cyc();
        req_valid = '0;
        settle();
        chk("um_ren_c1", 64'({bus_ren, bus_wen}), 64'h2);
        next_cyc();
        bus_addr_valid = 1'b1;
        settle();
        chk("um_resp_valid_c2", 64'(resp_valid), 64'h1);
        chk("um_err_c2", 64'(resp_err), 64'h1);
        chk("um_rdata_c2", 64'(resp_rdata), 64'h0);

        // ---- timeout (TIMEOUT=4): requester 1 wins, requester 2 waits
        next_cyc();
        req_valid = 3'b110;
        bus_busy  = 1'b1;
        settle();
        chk("to_req_ready_c0", 64'(req_ready), 64'h2);
        for (int c = 1; c <= 4; c++) begin
            next_cyc();
            req_valid = 3'b100;
            settle();
            chk($sformatf("to_ren_c%0d", c), 64'({bus_ren, bus_wen}), 64'h2);
            chk($sformatf("to_req_ready_c%0d", c), 64'(req_ready), 64'h0);
            chk($sformatf("to_resp_valid_c%0d", c), 64'(resp_valid), 64'h0);
        end
        next_cyc();
        settle();
        chk("to_resp_valid_c5", 64'(resp_valid), 64'h2);
        chk("to_err_c5", 64'(resp_err), 64'h1);
        chk("to_rdata_c5", 64'(resp_rdata), 64'h0);
        chk("to_strobes_c5", 64'({bus_ren, bus_wen}), 64'h0);
        chk("to_req_ready_c5", 64'(req_ready), 64'h0);
        next_cyc();
        bus_busy = 1'b0;
        settle();
        chk("to_next_grant_c6", 64'(req_ready), 64'h4);
        next_cyc();
        req_valid = '0;
        next_cyc();
        settle();
        chk("to_next_resp_c8", 64'(resp_valid), 64'h4);
        chk("to_next_err_c8", 64'(resp_err), 64'h0);

        // ---- reset during ACCESS of a read (last is 2)
        next_cyc();
        req_valid = 3'b010;
        settle();
        chk("rr_mid_req_ready_c0", 64'(req_ready), 64'h2);
        next_cyc();
        req_valid = '0;
        bus_busy  = 1'b1;
        rst       = 1'b1;
        settle();
        chk("rst_mid_ren_c1", 64'({bus_ren, bus_wen}), 64'h2);
        next_cyc();
        rst       = 1'b0;
        bus_busy  = 1'b0;
        req_valid = 3'b011;
        settle();
        chk("rst_mid_strobes_c2", 64'({bus_ren, bus_wen}), 64'h0);
        chk("rst_mid_resp_valid_c2", 64'(resp_valid), 64'h0);
        chk("rst_mid_first_grant_c2", 64'(req_ready), 64'h1);
        next_cyc();
        req_valid = '0;
        settle();
        chk("rst_mid_resp_valid_c3", 64'(resp_valid), 64'h0);
        chk("rst_mid_ren_c3", 64'({bus_ren, bus_wen}), 64'h2);
        next_cyc();
        settle();
        chk("rst_mid_resp_valid_c4", 64'(resp_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_req_scheduler.md
Name: bus_req_scheduler

Overview:
- Round-robin scheduler that shares one memory-mapped slave bus between NREQ requesters (core data port, debug, DMA).
- Accepts one request at a time and drives the shared bus strobes. Waits out slave wait-states.
- Returns read data or an error to the winning requester.
- Sits upstream of the slave read-data mux and address decoders. Consumes the decoder's combined address-valid and the muxed read data.

Parameters:
- NREQ, 3, number of requesters (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum busy cycles before an access is aborted with error (8-bit counter, 1..255).

Ports:
- wb_clk_i  in  1  clock; all logic is rising-edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request pending.
- req_wen  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  NREQ  one-hot completion pulse.
- resp_rdata  out  DATA_W  read data, shared; valid while resp_valid is nonzero.
- resp_err  out  1  error flag qualified by resp_valid.
- bus_addr  out  ADDR_W  shared bus address.
- bus_wdata  out  DATA_W  shared bus write data.
- bus_ren  out  1  read strobe.
- bus_wen  out  1  write strobe.
- bus_rdata  in  DATA_W  muxed slave read data.
- bus_busy  in  1  slave wait-state.
- bus_addr_valid  in  1  OR of all decoder address-valid lines.

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Timeout counter 0.
- Reset mid-transaction drops the access: no resp_valid is issued, bus strobes are 0 on the next cycle.
- FSM IDLE:
  - If any req_valid is set, the winner is the first set bit scanning last+1, last+2, … modulo NREQ.
  - Same cycle: req_ready[winner]=1 (combinational from state and req_valid). Latch winner index, addr, wdata and wen; last <= winner; go to ACCESS.
  - If no req_valid is set, stay in IDLE.
- FSM ACCESS:
  - bus_addr and bus_wdata come from the latched values. bus_ren = ~wen and bus_wen = wen, held for the whole state.
  - If bus_addr_valid=0: finish with err=1, rdata=0.
  - Else if bus_busy=1: counter++. If counter reaches TIMEOUT, finish with err=1, rdata=0.
  - Else: finish with err=0; rdata = bus_rdata for reads, 0 for writes.
  - Finishing registers the result and moves to RESP.
- FSM RESP:
  - resp_valid[winner]=1 for exactly one cycle, with resp_rdata and resp_err driven.
  - Strobes are 0; counter is cleared; go to IDLE.
- Latency:
  - No wait-states: request accepted in cycle 0, strobes in cycle 1, response in cycle 2.
  - Each busy cycle adds one cycle.
  - Back-to-back throughput: one access per 3 cycles.
- Requester obligation: req_valid/addr/wdata are sampled only in the req_ready cycle and may change afterwards. A requester holding req_valid after req_ready is treated as a new request.
- Simultaneous requests: exactly one req_ready bit per cycle. A requester continuously requesting waits at most NREQ-1 grants.
- resp_valid and req_ready are never both nonzero in the same cycle.
- Counter width is 8 bits. TIMEOUT=255 aborts on the 255th consecutive busy cycle.
- bus_rdata is ignored outside ACCESS. resp_rdata is 0 whenever resp_valid=0.

Decomposition:
- Shared package holds:
  - State enum: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - TIMEOUT_W=8.
  - Error-response data constant, all zeros.
- One sub-module, rr_arbiter_pick: combinational.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, winner index, any flag.
  - Reusable by other shared-resource blocks.
- FSM, latches and counter stay in the top.

Test Plan:
- Single read, requester 1:
  - Stimulus: addr 0x8000_0004, bus_addr_valid=1, no busy, bus_rdata=0xDEAD_BEEF.
  - Response: req_ready=3'b010 in cycle 0; bus_ren=1 in cycle 1; resp_valid=3'b010 with rdata 0xDEAD_BEEF and err=0 in cycle 2.
- All three requesters hold req_valid from reset: grants in order 0,1,2,0,1,2 at cycles 0,3,6,9,12,15.
- Write with 2 wait-states, requester 2:
  - Stimulus: wdata 0x1234_5678, bus_busy high for 2 cycles.
  - Response: bus_wen high for 3 cycles; resp_valid=3'b100 with err=0 and rdata=0 one cycle later.
- Unmapped address (bus_addr_valid=0) -> resp_err=1 and resp_rdata=0 two cycles after accept.
- TIMEOUT=4 with bus_busy stuck at 1 -> strobe high for 4 cycles; resp_err=1; scheduler returns to IDLE and grants the next requester.
- wb_rst_i asserted during ACCESS of a read -> next cycle strobes=0 and no resp_valid; after release, requester 0 wins first.
